bus_master_port: RTL and testbench

- Master-side endpoint of the unidirectional bus protocol (2 masters, 4 slaves, one bus arbiter).
- Takes a burst command from local logic and raises this master's Req line. It holds Req while waiting for Ack, then drives address, select and write data onto the bus, and collects read data.
- Releases Req when the burst ends.
- One instance per master; its Req and Ack connect to one bit of the arbiter's Req and Ack vectors.

---
 rtl/bus_master_port_if.sv | 47 ++++
 rtl/bus_master_port.sv | 181 ++++++++++++++++++
 tb/tb_bus_master_port.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_port_if.sv
// Bus-side signal bundle for one master port: arbiter handshake (Req/Ack)
// plus the beat-level address/data/select lines shared with the slaves.
interface bus_master_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  // Arbiter handshake
  logic              Req;
  logic              Ack;

  // Beat signalling driven by the master
  logic              bus_valid;
  logic              bus_write;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;

  // Beat completion returned by the selected slave
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  modport master (
    output Req,
    output bus_valid,
    output bus_write,
    output bus_sel,
    output bus_addr,
    output bus_wdata,
    input  Ack,
    input  bus_rdata,
    input  bus_ready
  );

  modport slave (
    input  Req,
    input  bus_valid,
    input  bus_write,
    input  bus_sel,
    input  bus_addr,
    input  bus_wdata,
    output Ack,
    output bus_rdata,
    output bus_ready
  );

endinterface

// File: rtl/bus_master_port.sv
// Master-side bus endpoint: accepts a burst command, requests the bus,
// runs cmd_len+1 beats once granted, returns read data, and signals
// done on completion or err when a beat stalls for TIMEOUT cycles.
module bus_master_port #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,

  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,

  bus_master_port_if.master bus,

  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err
);

  // Low address field wraps inside the slave window selected by the top 2 bits
  localparam int LOW_W = ADDR_W - 2;
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_RELEASE,
    ST_ABORT
  } state_t;

  state_t            state_reg;
  logic              req_reg;
  logic              write_reg;
  logic [3:0]        sel_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  beat_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic              done_reg;
  logic              err_reg;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_data_reg;

  logic              accept;
  logic              beat_active;
  logic              beat_done;
  logic              beat_stall;
  logic              last_beat;
  logic              tmo_hit;
  logic [3:0]        sel_dec;

  // One-hot slave select decoded from the incoming command address
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel_dec
      assign sel_dec[gi] = (cmd_addr[ADDR_W-1:ADDR_W-2] == 2'(gi));
    end
  endgenerate

  // Handshake and beat qualifiers; cmd_ready is forced low while in reset
  assign cmd_ready   = reset & (state_reg == ST_IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign beat_active = (state_reg == ST_XFER) & bus.Ack;
  assign beat_done   = beat_active & bus.bus_ready;
  assign beat_stall  = beat_active & ~bus.bus_ready;
  assign last_beat   = beat_done & (beat_cnt_reg == len_reg);
  assign tmo_hit     = beat_stall & (tmo_cnt_reg == TMO_LAST);

  // Bus outputs: valid follows the live grant so a dropped Ack stalls at once
  assign bus.Req       = req_reg;
  assign bus.bus_valid = beat_active;
  assign bus.bus_write = write_reg;
  assign bus.bus_sel   = sel_reg;
  assign bus.bus_addr  = addr_reg;
  assign bus.bus_wdata = (beat_active & write_reg) ? wr_data : '0;

  // Write data is consumed in the very cycle its beat completes
  assign wr_pop   = beat_done & write_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign done     = done_reg;
  assign err      = err_reg;

  // Burst sequencer with registered Req/select/direction and end-of-burst pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      write_reg    <= 1'b0;
      sel_reg      <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg    <= ST_REQ;
            req_reg      <= 1'b1;
            write_reg    <= cmd_write;
            sel_reg      <= sel_dec;
            addr_reg     <= cmd_addr;
            len_reg      <= cmd_len;
            beat_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
          end
        end
        ST_REQ: begin
          if (bus.Ack) begin
            state_reg <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_done) begin
            tmo_cnt_reg           <= '0;
            beat_cnt_reg          <= beat_cnt_reg + LEN_W'(1);
            addr_reg[LOW_W-1:0]   <= addr_reg[LOW_W-1:0] + LOW_W'(1);
            if (last_beat) begin
              state_reg <= ST_RELEASE;
              req_reg   <= 1'b0;
              write_reg <= 1'b0;
              sel_reg   <= '0;
              done_reg  <= 1'b1;
            end
          end else if (tmo_hit) begin
            // Remaining beats are dropped; the burst never reports done
            state_reg   <= ST_ABORT;
            req_reg     <= 1'b0;
            write_reg   <= 1'b0;
            sel_reg     <= '0;
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b1;
          end else if (beat_stall) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        ST_RELEASE: begin
          state_reg <= ST_IDLE;
        end
        ST_ABORT: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Read return path: slave data registered one cycle after each read beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= beat_done & ~write_reg;
      if (beat_done & ~write_reg) begin
        rd_data_reg <= bus.bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: stimulus pushes expected beats,
// read data and end-of-burst events; a negedge monitor pops and compares.
module tb_bus_master_port;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int TO = 15;

  typedef struct packed {
    logic       wr;
    logic [3:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_pop;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;

  bus_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bm ();

  bus_master_port #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .LEN_W  (LW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_pop   (wr_pop),
    .bus      (bm),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .done     (done),
    .err      (err)
  );

  logic [7:0] rmem [256];
  logic [7:0] wr_mem [32];
  assign bm.bus_rdata = rmem[bm.bus_addr];

  beat_t      exp_beat [$];
  logic [7:0] exp_rd [$];
  int         exp_end [$];   // 0 = done, 1 = err

  int   checks = 0;
  int   errors = 0;
  int   beats_seen = 0;
  int   ends_seen = 0;
  int   pop_total = 0;
  int   stall_cnt = 0;
  int   req_age = 0;
  int   ack_delay = 2;
  logic ack_block = 1'b0;
  logic rd_due = 1'b0;
  logic end_due = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; model the arbiter grant and the write-data producer
  task automatic step();
    @(posedge clk);
    #1;
    if (!bm.Req) begin
      req_age = 0;
      bm.Ack  = 1'b0;
    end else begin
      req_age++;
      bm.Ack = (req_age > ack_delay) && !ack_block;
    end
    wr_data = wr_mem[pop_total];
  endtask

  task automatic push_beat(input logic w, input logic [3:0] s, input logic [7:0] a,
                           input logic [7:0] d, input logic l);
    beat_t b;
    b.wr = w; b.sel = s; b.addr = a; b.wdata = d; b.last = l;
    exp_beat.push_back(b);
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int target);
    int n = 0;
    while (ends_seen < target && n < 300) begin
      step();
      n++;
    end
    if (ends_seen < target) chk("end_wait_timeout", ends_seen, target);
  endtask

  // Monitor: compare every beat, read return and end-of-burst event
  initial begin
    beat_t b;
    logic [7:0] d;
    int k;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rd_due || rd_valid) begin
          chk("rd_valid_timing", {31'd0, rd_valid}, {31'd0, rd_due});
          if (rd_valid) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
              d = exp_rd.pop_front();
              chk("rd_data", rd_data, d);
              $display("read  data=%h", rd_data);
            end
          end
        end
        rd_due = 1'b0;
        if (end_due || done || err) begin
          chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
          if (end_due) chk("done_timing", {31'd0, done}, 32'd1);
          if (exp_end.size() == 0) chk("end_unexpected", {30'd0, err, done}, 32'd0);
          else begin
            k = exp_end.pop_front();
            chk("end_kind", {30'd0, err, done}, (k == 1) ? 32'd2 : 32'd1);
            chk("end_req_low", {31'd0, bm.Req}, 32'd0);
            $display("end   done=%0b err=%0b", done, err);
          end
          ends_seen++;
        end
        end_due = 1'b0;
        if (bm.bus_valid && bm.bus_ready) begin
          if (exp_beat.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
          else begin
            b = exp_beat.pop_front();
            chk("beat_addr", bm.bus_addr, b.addr);
            chk("beat_sel", bm.bus_sel, b.sel);
            chk("beat_write", {31'd0, bm.bus_write}, {31'd0, b.wr});
            chk("beat_wr_pop", {31'd0, wr_pop}, {31'd0, b.wr});
            if (b.wr) chk("beat_wdata", bm.bus_wdata, b.wdata);
            if (!b.wr) rd_due = 1'b1;
            if (b.last) end_due = 1'b1;
            $display("beat  wr=%0b sel=%b addr=%h wdata=%h", bm.bus_write, bm.bus_sel,
                     bm.bus_addr, bm.bus_wdata);
          end
          beats_seen++;
        end else begin
          if (wr_pop) chk("spurious_wr_pop", 32'd1, 32'd0);
          if (bm.bus_valid) stall_cnt++;
        end
        if (wr_pop) pop_total++;
      end
    end
  end

  initial begin
    int b0;
    int e0;
    int p0;
    int n;
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
    for (int i = 0; i < 32; i++) wr_mem[i] = 8'h00;
    wr_mem[0] = 8'hA5;
    wr_mem[1] = 8'hC1; wr_mem[2] = 8'hC2; wr_mem[3] = 8'hC3; wr_mem[4] = 8'hC4;
    wr_mem[5] = 8'h5A;
    rmem[8'hC2] = 8'h11; rmem[8'hC3] = 8'h22; rmem[8'hC4] = 8'h33; rmem[8'hC5] = 8'h44;
    rmem[8'h3E] = 8'h77; rmem[8'h3F] = 8'h88; rmem[8'h00] = 8'h55; rmem[8'h01] = 8'h66;
    rmem[8'h44] = 8'h9A; rmem[8'h45] = 8'h9B; rmem[8'h46] = 8'h9C; rmem[8'h47] = 8'h9D;

    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = wr_mem[0];
    bm.Ack = 1'b0;
    bm.bus_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bm.Req}, 32'd0);
    chk("rst_bus_valid", {31'd0, bm.bus_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_sel", bm.bus_sel, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("rst_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Single write, Ack two cycles after Req
    bm.bus_ready = 1'b1;
    push_beat(1'b1, 4'b0010, 8'h40, 8'hA5, 1'b1);
    exp_end.push_back(0);
    e0 = ends_seen;
    issue(1'b1, 8'h40, 4'd0);
    chk("single_req_after_accept", {31'd0, bm.Req}, 32'd1);
    wait_end(e0 + 1);

    // Read burst into slave 3
    for (int i = 0; i < 4; i++) push_beat(1'b0, 4'b1000, 8'hC2 + 8'(i), 8'h00, i == 3);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
    exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
    exp_end.push_back(0);
    e0 = ends_seen;
    issue(1'b0, 8'hC2, 4'd3);
    wait_end(e0 + 1);

    // Address wrap inside slave 0 window
    push_beat(1'b0, 4'b0001, 8'h3E, 8'h00, 1'b0);
    push_beat(1'b0, 4'b0001, 8'h3F, 8'h00, 1'b0);
    push_beat(1'b0, 4'b0001, 8'h00, 8'h00, 1'b0);
    push_beat(1'b0, 4'b0001, 8'h01, 8'h00, 1'b1);
    exp_rd.push_back(8'h77); exp_rd.push_back(8'h88);
    exp_rd.push_back(8'h55); exp_rd.push_back(8'h66);
    exp_end.push_back(0);
    e0 = ends_seen;
    issue(1'b0, 8'h3E, 4'd3);
    wait_end(e0 + 1);

    // Grant loss after the first beat of a 4-beat write
    for (int i = 0; i < 4; i++) push_beat(1'b1, 4'b0100, 8'h80 + 8'(i), 8'hC1 + 8'(i), i == 3);
    exp_end.push_back(0);
    e0 = ends_seen;
    b0 = beats_seen;
    p0 = pop_total;
    issue(1'b1, 8'h80, 4'd3);
    n = 0;
    while (beats_seen < b0 + 1 && n < 100) begin
      step();
      n++;
    end
    chk("grant_first_beat", beats_seen - b0, 32'd1);
    ack_block = 1'b1;
    bm.Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("grant_loss_valid", {31'd0, bm.bus_valid}, 32'd0);
      chk("grant_loss_req", {31'd0, bm.Req}, 32'd1);
      step();
    end
    ack_block = 1'b0;
    bm.Ack = 1'b1;
    wait_end(e0 + 1);
    chk("grant_loss_pops", pop_total - p0, 32'd4);

    // Timeout: slave never ready
    bm.bus_ready = 1'b0;
    exp_end.push_back(1);
    e0 = ends_seen;
    stall_cnt = 0;
    issue(1'b1, 8'h10, 4'd0);
    wait_end(e0 + 1);
    chk("timeout_stall_cycles", stall_cnt, 32'd15);
    chk("timeout_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("timeout_req_low", {31'd0, bm.Req}, 32'd0);
    bm.bus_ready = 1'b1;
    push_beat(1'b1, 4'b0001, 8'h20, 8'h5A, 1'b1);
    exp_end.push_back(0);
    e0 = ends_seen;
    issue(1'b1, 8'h20, 4'd0);
    wait_end(e0 + 1);

    // Asynchronous reset in the middle of a read burst
    for (int i = 0; i < 4; i++) push_beat(1'b0, 4'b0010, 8'h44 + 8'(i), 8'h00, i == 3);
    exp_rd.push_back(8'h9A); exp_rd.push_back(8'h9B);
    exp_rd.push_back(8'h9C); exp_rd.push_back(8'h9D);
    exp_end.push_back(0);
    b0 = beats_seen;
    issue(1'b0, 8'h44, 4'd3);
    n = 0;
    while (beats_seen < b0 + 2 && n < 100) begin
      step();
      n++;
    end
    chk("reset_two_beats", beats_seen - b0, 32'd2);
    #3 reset = 1'b0;
    bm.Ack = 1'b0;
    #1;
    chk("async_req", {31'd0, bm.Req}, 32'd0);
    chk("async_bus_valid", {31'd0, bm.bus_valid}, 32'd0);
    chk("async_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_addr", bm.bus_addr, 32'd0);
    chk("async_sel", bm.bus_sel, 32'd0);
    chk("async_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    exp_beat.delete();
    exp_rd.delete();
    exp_end.delete();
    rd_due = 1'b0;
    end_due = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("async_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 10; i++) step();

    chk("beat_queue_empty", exp_beat.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("end_queue_empty", exp_end.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
